// File: rtl/pipe_pkg.sv
// Shared pipeline types: stage-register state encoding, occupancy width and default stage payload widths.
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_FULL  = 2'd1,
    PS_SKID  = 2'd2
  } pipe_state_t;

  localparam int PIPE_OCC_W = 2;

  // Default packed widths of the per-stage structs carried through pipe_stage_reg.
  localparam int IF_ID_W  = 32;
  localparam int ID_EX_W  = 128;
  localparam int EX_MEM_W = 96;
  localparam int MEM_WB_W = 72;

  function automatic logic [PIPE_OCC_W-1:0] pipe_occ(input pipe_state_t s);
    case (s)
      PS_FULL: return 2'd1;
      PS_SKID: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter for performance statistics; cleared only by the active-low async reset.
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign count = cnt_q;
  assign sat   = &cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && !sat) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with flush and saturating stall accounting.
// Define PIPE_STAGE_SKID_EN for a 2-entry skid build with a registered in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = IF_ID_W,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  input  logic                  out_ready,
  input  logic                  flush,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [PIPE_OCC_W-1:0] occupancy
);

  pipe_state_t      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic             live_q;
  logic             in_fire;
  logic             stall_inc;
  logic             stall_sat;

`ifdef PIPE_STAGE_SKID_EN
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             rdy_q;

  // Flush always accepts (and drops) the input beat, even when the skid slot is occupied.
  assign in_ready = rdy_q | (flush & live_q);
`else
  assign in_ready = live_q & ((state_q == PS_EMPTY) | out_ready | flush);
`endif

  assign in_fire   = in_valid & in_ready & ~flush;
  assign out_valid = (state_q != PS_EMPTY);
  assign out_data  = main_q;
  assign occupancy = pipe_occ(state_q);
  assign stall_inc = out_valid & ~out_ready & ~flush & ~stall_sat;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
`ifdef PIPE_STAGE_SKID_EN
    skid_d  = skid_q;
`endif
    if (flush) begin
      state_d = PS_EMPTY;
    end else begin
      case (state_q)
        PS_EMPTY: begin
          if (in_fire) begin
            state_d = PS_FULL;
            main_d  = in_data;
          end
        end
        PS_FULL: begin
          if (out_ready) begin
            if (in_fire) main_d  = in_data;
            else         state_d = PS_EMPTY;
          end
`ifdef PIPE_STAGE_SKID_EN
          else if (in_fire) begin
            state_d = PS_SKID;
            skid_d  = in_data;
          end
`endif
        end
        PS_SKID: begin
`ifdef PIPE_STAGE_SKID_EN
          if (out_ready) begin
            state_d = PS_FULL;
            main_d  = skid_q;
          end
`else
          state_d = PS_EMPTY;
`endif
        end
        default: state_d = PS_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= PS_EMPTY;
      main_q  <= '0;
      live_q  <= 1'b0;
`ifdef PIPE_STAGE_SKID_EN
      skid_q  <= '0;
      rdy_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      live_q  <= 1'b1;
`ifdef PIPE_STAGE_SKID_EN
      skid_q  <= skid_d;
      rdy_q   <= (state_d != PS_SKID);
`endif
    end
  end

  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cnt),
    .sat   (stall_sat)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized and directed bench for pipe_stage_reg, checked against a queue-based model of the stage.
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;
  logic        flush;

  logic        in_ready,  out_valid;
  logic [31:0] out_data;
  logic [15:0] stall_cnt;
  logic [1:0]  occupancy;

  logic        in_ready_b, out_valid_b;
  logic [31:0] out_data_b;
  logic [1:0]  stall_cnt_b;
  logic [1:0]  occupancy_b;

  pipe_stage_reg #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .flush(flush),
    .stall_cnt(stall_cnt), .occupancy(occupancy)
  );

  pipe_stage_reg #(.WIDTH(32), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_b),
    .out_valid(out_valid_b), .out_data(out_data_b), .out_ready(out_ready), .flush(flush),
    .stall_cnt(stall_cnt_b), .occupancy(occupancy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model: the stage is a FIFO of held beats with capacity 1 or 2.
  logic [31:0] mq[$];
  bit          m_live;
  int          m_stall;

  task automatic model_reset();
    mq.delete();
    m_live  = 1'b0;
    m_stall = 0;
  endtask

  task automatic cycle(input logic iv, input logic [31:0] id, input logic ordy, input logic fl,
                       output bit acc);
    bit exp_v, exp_rdy;
    int cap_main, cap_b;
    @(negedge clk);
    in_valid = iv; in_data = id; out_ready = ordy; flush = fl;
    #1;
    exp_v = (mq.size() > 0);
    if (!rst || !m_live)  exp_rdy = 1'b0;
    else if (SKID)        exp_rdy = (mq.size() < 2) || fl;
    else                  exp_rdy = (mq.size() == 0) || ordy || fl;
    cap_main = (m_stall > 65535) ? 65535 : m_stall;
    cap_b    = (m_stall > 3) ? 3 : m_stall;
    check("out_valid", out_valid, exp_v);
    if (exp_v) check("out_data", out_data, mq[0]);
    check("in_ready", in_ready, exp_rdy);
    check("occupancy", occupancy, mq.size());
    check("stall_cnt", stall_cnt, cap_main);
    check("out_valid_w2", out_valid_b, exp_v);
    if (exp_v) check("out_data_w2", out_data_b, mq[0]);
    check("in_ready_w2", in_ready_b, exp_rdy);
    check("occupancy_w2", occupancy_b, mq.size());
    check("stall_cnt_w2", stall_cnt_b, cap_b);
    acc = iv && exp_rdy && !fl;
    @(posedge clk);
    if (!rst) begin
      model_reset();
      acc = 1'b0;
    end else begin
      if (fl) begin
        mq.delete();
      end else begin
        if (exp_v && ordy) $display("out beat %08h", mq.pop_front());
        if (acc) mq.push_back(id);
      end
      if (exp_v && !ordy && !fl) m_stall++;
      m_live = 1'b1;
    end
  endtask

  task automatic step(input logic iv, input logic [31:0] id, input logic ordy, input logic fl);
    bit acc;
    cycle(iv, id, ordy, fl, acc);
  endtask

  task automatic reset_stage();
    #2 rst = 1'b0;
    model_reset();
    step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    #2 rst = 1'b1;
  endtask

  logic [31:0] src[$];
  int          sat_seq[6] = '{1, 2, 3, 3, 3, 3};

  initial begin
    bit acc;
    bit ordy;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
    model_reset();
    #1;

    // Reset with a live input beat: nothing is captured or signalled.
    reset_stage();

    // Back-to-back stream with no backpressure.
    src = '{32'd1, 32'd2, 32'd3, 32'd4};
    for (int t = 0; t < 8; t++) begin
      cycle(src.size() > 0, (src.size() > 0) ? src[0] : 32'd0, 1'b1, 1'b0, acc);
      if (acc) void'(src.pop_front());
    end
    check("stream_src_drained", src.size(), 0);

    // Three cycles of backpressure once A is valid.
    reset_stage();
    step(1'b0, 32'd0, 1'b1, 1'b0);
    src = '{32'h11, 32'h22};
    for (int t = 0; t < 8; t++) begin
      ordy = !(t >= 1 && t <= 3);
      cycle(src.size() > 0, (src.size() > 0) ? src[0] : 32'd0, ordy, 1'b0, acc);
      if (acc) void'(src.pop_front());
    end
    check("bp_stall_cnt", stall_cnt, 3);

    // Flush with a full stage and a competing input beat.
    reset_stage();
    step(1'b1, 32'hA1, 1'b0, 1'b0);
    step(1'b1, 32'hA2, 1'b0, 1'b0);
    step(1'b1, 32'h33, 1'b0, 1'b1);
    #1;
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_occupancy", occupancy, 0);
    for (int t = 0; t < 3; t++) step(1'b0, 32'd0, 1'b1, 1'b0);

    // Saturation of the narrow counter.
    reset_stage();
    step(1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b1, 32'h44, 1'b1, 1'b0);
    for (int t = 0; t < 6; t++) begin
      step(1'b0, 32'd0, 1'b0, 1'b0);
      #1;
      check("sat_seq", stall_cnt_b, sat_seq[t]);
      check("wide_seq", stall_cnt, t + 1);
    end
    step(1'b0, 32'd0, 1'b1, 1'b0);

    // Asynchronous reset between clock edges while the stage is loaded.
    reset_stage();
    step(1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b1, 32'h61, 1'b1, 1'b0);
    step(1'b1, 32'h62, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("async_out_valid", out_valid, 1'b0);
    check("async_in_ready", in_ready, 1'b0);
    check("async_occupancy", occupancy, 0);
    check("async_out_valid_w2", out_valid_b, 1'b0);
    model_reset();
    step(1'b0, 32'd0, 1'b1, 1'b0);
    #2 rst = 1'b1;
    src = '{32'h55};
    for (int t = 0; t < 5; t++) begin
      cycle(src.size() > 0, (src.size() > 0) ? src[0] : 32'd0, 1'b1, 1'b0, acc);
      if (acc) void'(src.pop_front());
    end

    // Randomized traffic with occasional flushes.
    reset_stage();
    for (int t = 0; t < 400; t++) begin
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1) == 1,
           $urandom_range(0, 15) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
